// File: rtl/irq_aggregator_pkg.sv
// Shared constants for the interrupt aggregator: register map and VECTOR layout.
package irq_aggregator_pkg;

  localparam int unsigned MAX_SRC     = 16;
  localparam int unsigned VEC_IDX_W   = 4;
  localparam int unsigned VEC_ANY_BIT = 15;

  typedef logic [2:0] reg_addr_t;

  localparam reg_addr_t ADDR_STATUS  = 3'd0;
  localparam reg_addr_t ADDR_PENDING = 3'd1;
  localparam reg_addr_t ADDR_ENABLE  = 3'd2;
  localparam reg_addr_t ADDR_EDGE    = 3'd3;
  localparam reg_addr_t ADDR_VECTOR  = 3'd4;
  localparam reg_addr_t ADDR_FORCE   = 3'd5;

endpackage

// File: rtl/irq_aggregator_if.sv
// Avalon-MM slave register bus for the interrupt aggregator.
interface irq_aggregator_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the masked pending sources.
module irq_prio_enc
  import irq_aggregator_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]   req,
  output logic                 any,
  output logic [VEC_IDX_W-1:0] idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = VEC_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// Interrupt controller: latches edge/level sources, masks them and drives one registered irq.
module irq_aggregator
  import irq_aggregator_pkg::*;
#(
  parameter int unsigned        NUM_SRC      = 8,
  parameter logic [MAX_SRC-1:0] EDGE_DEFAULT = 16'h0001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  irq_aggregator_if.slave    bus,
  output logic               irq
);

  logic [NUM_SRC-1:0]   src_q, src_q_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [NUM_SRC-1:0]   enable_q, enable_d;
  logic [NUM_SRC-1:0]   edge_q, edge_d;
  logic                 irq_q;
  logic [15:0]          readdata_q, readdata_d;

  logic                 wr;
  logic [NUM_SRC-1:0]   wdata;
  logic [NUM_SRC-1:0]   w1c, force_set, ack_clr, onehot, set_bits, clr_bits;
  logic                 vec_any;
  logic [VEC_IDX_W-1:0] vec_idx;
  logic [15:0]          vector;
  logic                 unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[NUM_SRC-1:0];
  assign unused_wdata = ^bus.writedata;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req (pending_q & enable_q),
    .any (vec_any),
    .idx (vec_idx)
  );

  always_comb begin
    vector                       = '0;
    vector[VEC_ANY_BIT]          = vec_any;
    vector[VEC_IDX_W-1:0]        = vec_idx;
    onehot                       = NUM_SRC'(1) << vec_idx;
  end

  always_comb begin
    enable_d  = enable_q;
    edge_d    = edge_q;
    w1c       = '0;
    force_set = '0;
    ack_clr   = '0;
    if (wr) begin
      case (bus.address)
        ADDR_PENDING: w1c       = wdata;
        ADDR_ENABLE:  enable_d  = wdata;
        ADDR_EDGE:    edge_d    = wdata;
        ADDR_FORCE:   force_set = wdata;
        ADDR_VECTOR: begin
          if (vec_any && |(onehot & edge_q)) ack_clr = onehot;
        end
        default: ;
      endcase
    end
    // Edge bits: set beats clear. Level bits simply follow the synchronised source.
    set_bits  = ((src_q & ~src_q_d) | force_set) & edge_q;
    clr_bits  = (w1c | ack_clr) & edge_q;
    pending_d = (edge_q & ((pending_q & ~clr_bits) | set_bits)) | (~edge_q & src_q);
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_STATUS:  readdata_d = 16'(pending_q & enable_q);
      ADDR_PENDING: readdata_d = 16'(pending_q);
      ADDR_ENABLE:  readdata_d = 16'(enable_q);
      ADDR_EDGE:    readdata_d = 16'(edge_q);
      ADDR_VECTOR:  readdata_d = vector;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q      <= '0;
      src_q_d    <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      edge_q     <= EDGE_DEFAULT[NUM_SRC-1:0];
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      src_q      <= src;
      src_q_d    <= src_q;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      edge_q     <= edge_d;
      irq_q      <= |(pending_q & enable_q);
      readdata_q <= readdata_d;
    end
  end

  assign irq          = irq_q;
  assign bus.readdata = readdata_q;

endmodule
